// File: rtl/sram_bridge.sv
// CPU-to-SRAM-controller bridge: holds load/store for WAIT_CYCLES+1 cycles and returns a one-cycle response.
// Optional one-entry read cache enabled by defining SRAM_BRIDGE_READ_CACHE_EN.
module sram_bridge #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [18:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_abort,
    input  logic        prog_mode,
    output logic [18:0] mem_address,
    output logic [7:0]  mem_indata,
    output logic        mem_load,
    output logic        mem_store,
    input  logic [7:0]  mem_outdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

    localparam logic [3:0] HOLD_INIT = 4'(WAIT_CYCLES);

    state_t      state, state_next;
    logic [3:0]  hold_count, hold_next;
    logic [18:0] address_next;
    logic [7:0]  indata_next;
    logic [7:0]  rdata_next;
    logic        load_next, store_next, valid_next, abort_next;
    logic        accept;

`ifdef SRAM_BRIDGE_READ_CACHE_EN
    logic        cache_valid, cache_valid_next;
    logic [18:0] cache_tag, cache_tag_next;
    logic [7:0]  cache_data, cache_data_next;
    logic        cache_hit;

    assign cache_hit = cache_valid && (cache_tag == req_addr) && !req_write;
`endif

    assign req_ready = (state == IDLE) && !prog_mode;
    assign busy      = (state != IDLE) || prog_mode;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next   = state;
        hold_next    = hold_count;
        address_next = mem_address;
        indata_next  = mem_indata;
        load_next    = mem_load;
        store_next   = mem_store;
        rdata_next   = rsp_rdata;
        valid_next   = 1'b0;
        abort_next   = 1'b0;
`ifdef SRAM_BRIDGE_READ_CACHE_EN
        cache_valid_next = cache_valid;
        cache_tag_next   = cache_tag;
        cache_data_next  = cache_data;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef SRAM_BRIDGE_READ_CACHE_EN
                    if (cache_hit) begin
                        valid_next = 1'b1;
                        rdata_next = cache_data;
                    end else
`endif
                    begin
                        address_next = req_addr;
                        indata_next  = req_wdata;
                        hold_next    = HOLD_INIT;
                        if (req_write) begin
                            state_next = WRITE;
                            store_next = 1'b1;
                        end else begin
                            state_next = READ;
                            load_next  = 1'b1;
                        end
                    end
                end
            end
            READ, WRITE: begin
                // prog_mode steals the SRAM, so it overrides a completion on the same edge
                if (prog_mode) begin
                    load_next  = 1'b0;
                    store_next = 1'b0;
                    valid_next = 1'b1;
                    abort_next = 1'b1;
                    state_next = IDLE;
                end else if (hold_count == 4'd0) begin
                    load_next  = 1'b0;
                    store_next = 1'b0;
                    valid_next = 1'b1;
                    if (state == READ) begin
                        rdata_next = mem_outdata;
                        state_next = IDLE;
`ifdef SRAM_BRIDGE_READ_CACHE_EN
                        cache_valid_next = 1'b1;
                        cache_tag_next   = mem_address;
                        cache_data_next  = mem_outdata;
`endif
                    end else begin
                        state_next = TURN;
`ifdef SRAM_BRIDGE_READ_CACHE_EN
                        if (cache_valid && (cache_tag == mem_address)) begin
                            cache_data_next = mem_indata;
                        end
`endif
                    end
                end else begin
                    hold_next = hold_count - 4'd1;
                end
            end
            TURN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef SRAM_BRIDGE_READ_CACHE_EN
        if (prog_mode) begin
            cache_valid_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            hold_count  <= 4'd0;
            mem_address <= 19'd0;
            mem_indata  <= 8'd0;
            mem_load    <= 1'b0;
            mem_store   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'd0;
            rsp_abort   <= 1'b0;
`ifdef SRAM_BRIDGE_READ_CACHE_EN
            cache_valid <= 1'b0;
            cache_tag   <= 19'd0;
            cache_data  <= 8'd0;
`endif
        end else begin
            state       <= state_next;
            hold_count  <= hold_next;
            mem_address <= address_next;
            mem_indata  <= indata_next;
            mem_load    <= load_next;
            mem_store   <= store_next;
            rsp_valid   <= valid_next;
            rsp_rdata   <= rdata_next;
            rsp_abort   <= abort_next;
`ifdef SRAM_BRIDGE_READ_CACHE_EN
            cache_valid <= cache_valid_next;
            cache_tag   <= cache_tag_next;
            cache_data  <= cache_data_next;
`endif
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench for sram_bridge: vector table, scoreboard of responses, hand sequences for turnaround/abort/reset.
// Cache cases are included when SRAM_BRIDGE_READ_CACHE_EN is defined.
module tb_sram_bridge;

    localparam int TB_W = 2;

    logic        clock;
    logic        resetn;
    logic        req_valid, req_valid1;
    logic        req_write;
    logic [18:0] req_addr;
    logic [7:0]  req_wdata;
    logic        prog_mode;
    logic [7:0]  mem_outdata;

    logic        req_ready, rsp_valid, rsp_abort, mem_load, mem_store, busy;
    logic [7:0]  rsp_rdata, mem_indata;
    logic [18:0] mem_address;

    logic        req_ready1, rsp_valid1, rsp_abort1, mem_load1, mem_store1, busy1;
    logic [7:0]  rsp_rdata1, mem_indata1;
    logic [18:0] mem_address1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] rdata;
        logic       abort;
    } exp_t;

    exp_t sb_q[$];
    logic [7:0] model_rdata;

    typedef struct {
        logic        wr;
        logic [18:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  outdata;
        logic [7:0]  exp_rdata;
        int          exp_hold;
    } vec_t;

    vec_t vecs[6];

    sram_bridge #(.WAIT_CYCLES(TB_W)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_abort(rsp_abort),
        .prog_mode(prog_mode),
        .mem_address(mem_address), .mem_indata(mem_indata),
        .mem_load(mem_load), .mem_store(mem_store), .mem_outdata(mem_outdata),
        .busy(busy)
    );

    sram_bridge #(.WAIT_CYCLES(1)) dut1 (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_abort(rsp_abort1),
        .prog_mode(prog_mode),
        .mem_address(mem_address1), .mem_indata(mem_indata1),
        .mem_load(mem_load1), .mem_store(mem_store1), .mem_outdata(mem_outdata),
        .busy(busy1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic waitReady();
        for (int i = 0; i < 50; i++) begin
            if (req_ready) break;
            tick();
        end
        checkOutput("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    // Scoreboard and bus-exclusion monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (resetn) begin
            checkOutput("load_store_overlap", {31'd0, mem_load && mem_store}, 32'd0);
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checkOutput("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
                    checkOutput("rsp_abort", {31'd0, rsp_abort}, {31'd0, e.abort});
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [18:0] addr, input logic [7:0] wd,
                                 input logic [7:0] od, input logic [7:0] exp_rd, input int exp_hold);
        int hold, rsp_cnt, rsp_k;
        exp_t e;
        waitReady();
        req_write   = wr;
        req_addr    = addr;
        req_wdata   = wd;
        mem_outdata = od;
        req_valid   = 1'b1;
        e.rdata = exp_rd;
        e.abort = 1'b0;
        sb_q.push_back(e);
        tick();
        req_valid = 1'b0;
        hold = 0;
        rsp_cnt = 0;
        rsp_k = -1;
        for (int k = 0; k <= exp_hold + 1; k++) begin
            if (wr ? mem_store : mem_load) hold++;
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_k < 0) rsp_k = k;
            end
            if (k == 0 && exp_hold > 0) begin
                checkOutput("mem_address", {13'd0, mem_address}, {13'd0, addr});
                checkOutput("mem_indata", {24'd0, mem_indata}, {24'd0, wd});
            end
            if (k == exp_hold) checkOutput("ready_after_done", {31'd0, req_ready}, {31'd0, !wr});
            tick();
        end
        checkOutput("hold_cycles", hold, exp_hold);
        checkOutput("rsp_cycle", rsp_k, exp_hold);
        checkOutput("rsp_width", rsp_cnt, 1);
    endtask

    initial begin
        int st, acc_k, rsp_k, ld, rc;
        exp_t e;
        resetn = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; prog_mode = 1'b0; mem_outdata = '0;
        model_rdata = 8'h00;
        repeat (2) tick();
        checkOutput("rst_mem_load", {31'd0, mem_load}, 32'd0);
        checkOutput("rst_mem_store", {31'd0, mem_store}, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        checkOutput("rst_mem_address", {13'd0, mem_address}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        resetn = 1'b1;
        tick();

        vecs[0] = '{1'b0, 19'h00123, 8'h00, 8'h5A, 8'h5A, TB_W + 1};
        vecs[1] = '{1'b1, 19'h7FFFF, 8'hC3, 8'h00, 8'h5A, TB_W + 1};
        vecs[2] = '{1'b0, 19'h00456, 8'h00, 8'hA5, 8'hA5, TB_W + 1};
        vecs[3] = '{1'b1, 19'h00000, 8'h00, 8'h00, 8'hA5, TB_W + 1};
        vecs[4] = '{1'b0, 19'h7FFFF, 8'h00, 8'hFF, 8'hFF, TB_W + 1};
        vecs[5] = '{1'b0, 19'h00000, 8'h00, 8'h00, 8'h00, TB_W + 1};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].outdata,
                          vecs[i].exp_rdata, vecs[i].exp_hold);
        end
        model_rdata = 8'h00;

        // Write immediately followed by a held read: the read must wait out TURN
        waitReady();
        req_write = 1'b1; req_addr = 19'h7FFFF; req_wdata = 8'hC3; req_valid = 1'b1;
        e.rdata = model_rdata; e.abort = 1'b0; sb_q.push_back(e);
        tick();
        req_write = 1'b0; req_addr = 19'h00200; mem_outdata = 8'h3C;
        e.rdata = 8'h3C; e.abort = 1'b0; sb_q.push_back(e);
        st = 0; acc_k = -1; rsp_k = -1;
        for (int k = 0; k < 12; k++) begin
            if (mem_store) st++;
            if (mem_load && acc_k < 0) begin
                acc_k = k;
                req_valid = 1'b0;
            end
            if (rsp_valid && rsp_k < 0) rsp_k = k;
            tick();
        end
        req_valid = 1'b0;
        checkOutput("wr_store_cycles", st, 3);
        checkOutput("wr_rsp_cycle", rsp_k, 3);
        checkOutput("rd_after_turn", {31'd0, acc_k >= 4 && acc_k <= 5}, 32'd1);
        model_rdata = 8'h3C;

        // prog_mode raised one cycle after a read accept aborts it
        waitReady();
        req_write = 1'b0; req_addr = 19'h00300; mem_outdata = 8'h77; req_valid = 1'b1;
        e.rdata = model_rdata; e.abort = 1'b1; sb_q.push_back(e);
        tick();
        req_valid = 1'b0;
        prog_mode = 1'b1;
        tick();
        checkOutput("abort_mem_load", {31'd0, mem_load}, 32'd0);
        checkOutput("abort_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("abort_flag", {31'd0, rsp_abort}, 32'd1);
        checkOutput("abort_busy", {31'd0, busy}, 32'd1);
        req_addr = 19'h00301; mem_outdata = 8'h66; req_valid = 1'b1;
        e.rdata = 8'h66; e.abort = 1'b0; sb_q.push_back(e);
        for (int k = 0; k < 3; k++) begin
            checkOutput("prog_ready_low", {31'd0, req_ready}, 32'd0);
            checkOutput("prog_no_load", {31'd0, mem_load}, 32'd0);
            tick();
        end
        prog_mode = 1'b0;
        tick();
        req_valid = 1'b0;
        checkOutput("accept_after_prog", {31'd0, mem_load}, 32'd1);
        repeat (5) tick();
        model_rdata = 8'h66;

        // Reset asserted during a write drops it with no response
        waitReady();
        req_write = 1'b1; req_addr = 19'h00400; req_wdata = 8'h05; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        checkOutput("wr_store_before_rst", {31'd0, mem_store}, 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("rst_async_store", {31'd0, mem_store}, 32'd0);
        checkOutput("rst_async_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_async_rsp", {31'd0, rsp_valid}, 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        checkOutput("rst_release_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_release_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_release_rdata", {24'd0, rsp_rdata}, 32'd0);
        repeat (4) tick();
        model_rdata = 8'h00;

`ifdef SRAM_BRIDGE_READ_CACHE_EN
        applyStimulus(1'b0, 19'h00010, 8'h00, 8'h11, 8'h11, TB_W + 1);
        applyStimulus(1'b0, 19'h00010, 8'h00, 8'h99, 8'h11, 0);
        prog_mode = 1'b1;
        tick();
        prog_mode = 1'b0;
        applyStimulus(1'b0, 19'h00010, 8'h00, 8'h99, 8'h99, TB_W + 1);
        applyStimulus(1'b1, 19'h00010, 8'h44, 8'h00, 8'h99, TB_W + 1);
        applyStimulus(1'b0, 19'h00010, 8'h00, 8'hEE, 8'h44, 0);
`endif

        // WAIT_CYCLES=1 instance: two load cycles, response after E2
        checkOutput("w1_ready_idle", {31'd0, req_ready1}, 32'd1);
        req_write = 1'b0; req_addr = 19'h00077; req_wdata = 8'h1D; mem_outdata = 8'h42;
        req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        ld = 0; st = 0; rsp_k = -1; rc = 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_load1) ld++;
            if (mem_store1) st++;
            if (rsp_valid1) begin
                rc++;
                if (rsp_k < 0) rsp_k = k;
                checkOutput("w1_rsp_abort", {31'd0, rsp_abort1}, 32'd0);
            end
            if (k == 0) begin
                checkOutput("w1_mem_address", {13'd0, mem_address1}, 32'h00077);
                checkOutput("w1_mem_indata", {24'd0, mem_indata1}, 32'h1D);
            end
            tick();
        end
        checkOutput("w1_load_cycles", ld, 2);
        checkOutput("w1_store_cycles", st, 0);
        checkOutput("w1_rsp_cycle", rsp_k, 2);
        checkOutput("w1_rsp_width", rc, 1);
        checkOutput("w1_rsp_rdata", {24'd0, rsp_rdata1}, 32'h42);
        checkOutput("w1_ready_after", {31'd0, req_ready1}, 32'd1);
        checkOutput("w1_busy_after", {31'd0, busy1}, 32'd0);

        repeat (2) tick();
        checkOutput("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_bridge.md
SRAM_BRIDGE -- requirements
Module: sram_bridge

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the SRAM hold cycles beyond the first (legal range 1..14).
REQ-002 The block SHALL have port clock, input, 1, system clock.
REQ-003 The block SHALL have port resetn, input, 1, asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1, CPU request present.
REQ-005 The block SHALL have port req_ready, output, 1, bridge can accept a request.
REQ-006 The block SHALL have port req_write, input, 1, 1=write, 0=read.
REQ-007 The block SHALL have ports req_addr (input, 19, byte address) and req_wdata (input, 8, write byte).
REQ-008 The block SHALL have ports rsp_valid (output, 1, one-cycle completion pulse), rsp_rdata (output, 8, read byte) and rsp_abort (output, 1, completion was aborted).
REQ-009 The block SHALL have port prog_mode, input, 1, same signal as the SRAM controller prog input.
REQ-010 The block SHALL have ports mem_address (output, 19), mem_indata (output, 8), mem_load (output, 1), mem_store (output, 1) and mem_outdata (input, 8), wired to the SRAM controller address/indata/load/store/outdata.
REQ-011 The block SHALL have port busy, output, 1, high when state is not IDLE or prog_mode is high.

Function
REQ-012 The block SHALL implement states IDLE, READ, WRITE and TURN, with a 4-bit hold counter.
REQ-013 The block SHALL drive req_ready = (state==IDLE) && !prog_mode, combinationally.
REQ-014 A request SHALL be accepted on an edge E0 where req_valid && req_ready; req_addr and req_wdata SHALL be registered into mem_address and mem_indata at E0 and held stable until the next accept.
REQ-015 For a read, the block SHALL set mem_load=1 at E0 and keep it high through edge E(W+1), giving W+1 cycles with W=WAIT_CYCLES.
REQ-016 At E(W+1) the block SHALL deassert mem_load, capture mem_outdata into rsp_rdata, assert rsp_valid for exactly one cycle and return to IDLE.
REQ-017 For a write, the block SHALL set mem_store=1 at E0 and keep it high until E(W+1).
REQ-018 At E(W+1) of a write, the block SHALL assert rsp_valid for one cycle, leave rsp_rdata unchanged and enter TURN.
REQ-019 TURN SHALL last exactly one cycle with mem_store=0 and mem_load=0 (bus turnaround), then return to IDLE at E(W+2).
REQ-020 mem_load and mem_store SHALL never be high in the same cycle.
REQ-021 rsp_abort SHALL be 0 except as defined in REQ-022.
REQ-022 If prog_mode is sampled high in READ or WRITE, at that edge the block SHALL deassert mem_load and mem_store, pulse rsp_valid with rsp_abort=1 for one cycle, leave rsp_rdata unchanged and go to IDLE; no TURN cycle follows.
REQ-023 If prog_mode is high during TURN, the block SHALL complete TURN normally.
REQ-024 While prog_mode is high, req_ready SHALL stay 0 and no request SHALL be accepted; a pending req_valid SHALL be accepted on the first edge after prog_mode falls with state IDLE.
REQ-025 A request presented on the same edge that a transaction completes SHALL NOT be accepted, because req_ready is low that cycle.
REQ-026 The hold counter SHALL load WAIT_CYCLES at E0 and decrement to 0 without wrap; completion occurs on the edge where the counter is 0.

Reset
REQ-027 While resetn=0, the block SHALL asynchronously force state=IDLE, counter=0, mem_address=0, mem_indata=0, mem_load=0, mem_store=0, rsp_valid=0, rsp_rdata=0 and rsp_abort=0, and invalidate the read cache.
REQ-028 On reset assertion mid-transaction, the block SHALL drop the transaction with no rsp_valid pulse.

Configuration
REQ-029 With macro SRAM_BRIDGE_READ_CACHE_EN defined, the block SHALL keep a one-entry cache (valid bit, 19-bit tag, 8-bit data) loaded on every completed non-aborted read.
REQ-030 With SRAM_BRIDGE_READ_CACHE_EN defined, a write to the tagged address SHALL update the cached data; prog_mode high SHALL clear the valid bit.
REQ-031 With SRAM_BRIDGE_READ_CACHE_EN defined, a read hit at E0 SHALL pulse rsp_valid with the cached data at E0, leave mem_load 0, leave mem_address unchanged and remain in IDLE.
REQ-032 Without SRAM_BRIDGE_READ_CACHE_EN, no cache logic SHALL exist and every read SHALL follow REQ-015 and REQ-016.

Verification
REQ-033 The bench SHALL check: read addr 0x00123 (W=2) with mem_outdata=0x5A -> mem_load high 3 cycles, rsp_valid one cycle at E3, rsp_rdata=0x5A, req_ready high again after E3.
REQ-034 The bench SHALL check: write 0x7FFFF/0xC3 then immediate read -> mem_store high 3 cycles, rsp_valid at E3, TURN cycle, read accepted no earlier than E4, mem_load and mem_store never overlap.
REQ-035 The bench SHALL check: prog_mode raised 1 cycle after a read accept -> mem_load low next edge, rsp_valid=1 with rsp_abort=1, req_ready=0 until prog_mode falls.
REQ-036 The bench SHALL check: resetn low during WRITE -> mem_store=0 immediately (asynchronous), no rsp_valid, state IDLE after release.
REQ-037 The bench SHALL check, with SRAM_BRIDGE_READ_CACHE_EN: read 0x00010 twice -> second read gives rsp_valid at E0 with no mem_load; after a prog_mode pulse, the third read misses and takes 3 cycles.
REQ-038 The bench SHALL check: WAIT_CYCLES=1 read -> mem_load high 2 cycles, rsp_valid at E2.
